// File: rtl/core_sequencer.sv
// Instruction sequencer: steps one instruction through fetch, decode, execute,
// optional memory and write-back, owns the PC, counts retires, and traps hung stages.
module core_sequencer #(
    parameter int              PC_W     = 29,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            fetch_enable,
    input  logic            fetch_done,
    output logic            decode_enable,
    input  logic            decode_done,
    output logic            exec_enable,
    input  logic            exec_done,
    input  logic            mem_req,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            halt_req,
    output logic            mem_enable,
    input  logic            mem_done,
    output logic            wb_enable,
    input  logic            wb_done,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     instr_count,
    output logic            busy,
    output logic            halted,
    output logic            error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    // The watchdog only needs to count up to TIMEOUT-1 before firing.
    localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     count_q, count_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            mem_req_q, mem_req_d;
    logic            branch_q, branch_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            halt_q, halt_d;
    logic            fetch_en_q, fetch_en_d;
    logic            decode_en_q, decode_en_d;
    logic            exec_en_q, exec_en_d;
    logic            mem_en_q, mem_en_d;
    logic            wb_en_q, wb_en_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;
    logic            error_q, error_d;
    logic            stage_done;
    logic            in_stage;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        wdog_d     = wdog_q;
        mem_req_d  = mem_req_q;
        branch_d   = branch_q;
        target_d   = target_q;
        halt_d     = halt_q;
        stage_done = 1'b0;
        in_stage   = 1'b0;

        // A done is only believed once the stage's own enable pulse is over.
        case (state_q)
            S_FETCH:  begin in_stage = 1'b1; stage_done = fetch_done  & ~fetch_en_q;  end
            S_DECODE: begin in_stage = 1'b1; stage_done = decode_done & ~decode_en_q; end
            S_EXEC:   begin in_stage = 1'b1; stage_done = exec_done   & ~exec_en_q;   end
            S_MEM:    begin in_stage = 1'b1; stage_done = mem_done    & ~mem_en_q;    end
            S_WB:     begin in_stage = 1'b1; stage_done = wb_done     & ~wb_en_q;     end
            default:  ;
        endcase

        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_FETCH;
            S_FETCH:        if (stage_done) state_d = S_DECODE;
            S_DECODE:       if (stage_done) state_d = S_EXEC;
            S_EXEC: begin
                if (stage_done) begin
                    state_d   = mem_req ? S_MEM : S_WB;
                    mem_req_d = mem_req;
                    branch_d  = branch_taken;
                    target_d  = branch_target;
                    halt_d    = halt_req;
                end
            end
            S_MEM:          if (stage_done) state_d = S_WB;
            S_WB: begin
                if (stage_done) begin
                    count_d = count_q + 32'd1;
                    pc_d    = branch_q ? target_q : pc_q + PC_W'(1);
                    state_d = halt_q ? S_HALT : S_FETCH;
                end
            end
            default: ;
        endcase

        if (TIMEOUT > 0 && in_stage && !stage_done) begin
            if (wdog_q == WD_LAST) state_d = S_ERROR;
            else                   wdog_d  = wdog_q + WD_W'(1);
        end
        if (state_d != state_q) wdog_d = '0;

        fetch_en_d  = (state_d == S_FETCH)  && (state_q != S_FETCH);
        decode_en_d = (state_d == S_DECODE) && (state_q != S_DECODE);
        exec_en_d   = (state_d == S_EXEC)   && (state_q != S_EXEC);
        mem_en_d    = (state_d == S_MEM)    && (state_q != S_MEM);
        wb_en_d     = (state_d == S_WB)     && (state_q != S_WB);
        busy_d      = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC)
                   || (state_d == S_MEM)   || (state_d == S_WB);
        halted_d    = (state_d == S_HALT);
        error_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            count_q     <= '0;
            wdog_q      <= '0;
            mem_req_q   <= 1'b0;
            branch_q    <= 1'b0;
            target_q    <= '0;
            halt_q      <= 1'b0;
            fetch_en_q  <= 1'b0;
            decode_en_q <= 1'b0;
            exec_en_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            wb_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            wdog_q      <= wdog_d;
            mem_req_q   <= mem_req_d;
            branch_q    <= branch_d;
            target_q    <= target_d;
            halt_q      <= halt_d;
            fetch_en_q  <= fetch_en_d;
            decode_en_q <= decode_en_d;
            exec_en_q   <= exec_en_d;
            mem_en_q    <= mem_en_d;
            wb_en_q     <= wb_en_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            error_q     <= error_d;
        end
    end

    assign fetch_enable  = fetch_en_q;
    assign decode_enable = decode_en_q;
    assign exec_enable   = exec_en_q;
    assign mem_enable    = mem_en_q;
    assign wb_enable     = wb_en_q;
    assign pc            = pc_q;
    assign instr_count   = count_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign error         = error_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: table of whole instructions plus
// hand-written sequences for spurious dones, watchdog and mid-instruction reset.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic        fetch_enable, decode_enable, exec_enable, mem_enable, wb_enable;
    logic        fetch_done = 1'b0, decode_done = 1'b0, exec_done = 1'b0;
    logic        mem_done = 1'b0, wb_done = 1'b0;
    logic        mem_req = 1'b0, branch_taken = 1'b0, halt_req = 1'b0;
    logic [28:0] branch_target = '0;
    logic [28:0] pc;
    logic [31:0] instr_count;
    logic        busy, halted, error;

    int checks = 0;
    int errors = 0;

    core_sequencer #(.PC_W(29), .RESET_PC(29'd0), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .fetch_enable(fetch_enable), .fetch_done(fetch_done),
        .decode_enable(decode_enable), .decode_done(decode_done),
        .exec_enable(exec_enable), .exec_done(exec_done),
        .mem_req(mem_req), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req),
        .mem_enable(mem_enable), .mem_done(mem_done),
        .wb_enable(wb_enable), .wb_done(wb_done),
        .pc(pc), .instr_count(instr_count),
        .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start_first;
        logic        mem_req;
        logic        br;
        logic [28:0] tgt;
        logic        halt;
        logic [28:0] exp_pc;
        logic [31:0] exp_cnt;
        int          exp_lat;
        logic        exp_halted;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Raise one stage's done for the cycle after its enable, then drop it.
    task automatic handshake(input int s);
        @(negedge clk);
        case (s)
            0: fetch_done  = 1'b1;
            1: decode_done = 1'b1;
            2: exec_done   = 1'b1;
            3: mem_done    = 1'b1;
            default: wb_done = 1'b1;
        endcase
        @(negedge clk);
        fetch_done = 1'b0; decode_done = 1'b0; exec_done = 1'b0;
        mem_done = 1'b0; wb_done = 1'b0;
        mem_req = 1'b0; branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0;
    endtask

    task automatic run_instr(input vec_t v, output int lat);
        lat = 0;
        chk("fetch_en", {31'd0, fetch_enable}, 32'd1);
        handshake(0); lat += 2;
        chk("decode_en", {31'd0, decode_enable}, 32'd1);
        handshake(1); lat += 2;
        chk("exec_en", {31'd0, exec_enable}, 32'd1);
        @(negedge clk);
        exec_done = 1'b1; mem_req = v.mem_req; branch_taken = v.br;
        branch_target = v.tgt; halt_req = v.halt;
        @(negedge clk);
        exec_done = 1'b0; mem_req = 1'b0; branch_taken = 1'b0;
        branch_target = '0; halt_req = 1'b0;
        lat += 2;
        if (v.mem_req) begin
            chk("mem_en", {31'd0, mem_enable}, 32'd1);
            handshake(3); lat += 2;
        end else begin
            chk("mem_skip", {31'd0, mem_enable}, 32'd0);
        end
        chk("wb_en", {31'd0, wb_enable}, 32'd1);
        handshake(4); lat += 2;
    endtask

    vec_t vecs[6];

    initial begin
        int lat;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 29'h0,        1'b0, 29'd1,        32'd1, 8,  1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 29'h0,        1'b0, 29'd2,        32'd2, 10, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 29'h0,        1'b1, 29'd3,        32'd3, 8,  1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 29'h100,      1'b0, 29'h100,      32'd4, 10, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 29'h1FFFFFFF, 1'b0, 29'h1FFFFFFF, 32'd5, 8,  1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 29'h0,        1'b0, 29'd0,        32'd6, 8,  1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pc", {3'd0, pc}, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_flags", {27'd0, busy, halted, error, fetch_enable, wb_enable}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", {31'd0, busy}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].start_first) begin
                chk("halt_pc_hold", {3'd0, pc}, {3'd0, vecs[i-1].exp_pc});
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("resume_pc", {3'd0, pc}, {3'd0, vecs[i-1].exp_pc});
            end
            run_instr(vecs[i], lat);
            chk("pc", {3'd0, pc}, {3'd0, vecs[i].exp_pc});
            chk("count", instr_count, vecs[i].exp_cnt);
            chk("latency", lat, vecs[i].exp_lat);
            chk("halted", {31'd0, halted}, {31'd0, vecs[i].exp_halted});
            chk("next_fetch", {31'd0, fetch_enable}, {31'd0, ~vecs[i].exp_halted});
            $display("vec %0d: pc=%h count=%0d latency=%0d halted=%0b", i, pc, instr_count, lat, halted);
        end

        // Early exec_done, stray decode_done and start during EXEC must all be ignored.
        handshake(0);
        handshake(1);
        chk("sp_exec_en", {31'd0, exec_enable}, 32'd1);
        exec_done = 1'b1; decode_done = 1'b1; start = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("sp_early_done", {29'd0, mem_enable, wb_enable, busy}, 32'd1);
        @(negedge clk);
        chk("sp_stray_done", {29'd0, mem_enable, wb_enable, busy}, 32'd1);
        decode_done = 1'b0;
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0; start = 1'b0;
        chk("sp_wb_en", {31'd0, wb_enable}, 32'd1);
        handshake(4);
        chk("sp_pc", {3'd0, pc}, 32'd1);
        chk("sp_count", instr_count, 32'd7);
        $display("spurious: pc=%h count=%0d", pc, instr_count);

        // Fetch never answers: error exactly 16 cycles after fetch_enable.
        chk("wd_fetch_en", {31'd0, fetch_enable}, 32'd1);
        repeat (15) @(negedge clk);
        chk("wd_not_yet", {30'd0, busy, error}, 32'd2);
        @(negedge clk);
        chk("wd_error", {30'd0, busy, error}, 32'd1);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("wd_start_ign", {30'd0, error, fetch_enable}, 32'd2);
        chk("wd_pc_frozen", {3'd0, pc}, 32'd1);
        chk("wd_cnt_frozen", instr_count, 32'd7);
        $display("watchdog: error=%0b pc=%h count=%0d", error, pc, instr_count);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wd_rst", {29'd0, error, busy, halted}, 32'd0);
        chk("wd_rst_pc", {3'd0, pc}, 32'd0);

        // Reset in MEM takes effect before the next clock edge.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        handshake(0);
        handshake(1);
        @(negedge clk);
        exec_done = 1'b1; mem_req = 1'b1;
        @(negedge clk);
        exec_done = 1'b0; mem_req = 1'b0;
        chk("ar_mem_en", {31'd0, mem_enable}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_flags", {28'd0, mem_enable, busy, halted, error}, 32'd0);
        chk("ar_pc", {3'd0, pc}, 32'd0);
        chk("ar_cnt", instr_count, 32'd0);
        $display("async reset: busy=%0b pc=%h count=%0d", busy, pc, instr_count);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences one instruction at a time through the core's fetch, decode, execute, memory and write-back units using per-stage enable/done handshakes. It owns the program counter and applies branch redirects and halt requests reported by execute. It also counts retired instructions and traps hung stages with a watchdog.

Parameters:
PC_W, 29, program counter width, word-addressed; matches the decode addr field width.
RESET_PC, 0, PC value loaded by reset.
TIMEOUT, 1024, maximum cycles a stage may take to return done; 0 disables the watchdog.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin or resume execution; honoured only in IDLE or HALT
fetch_enable  out  1  one-cycle start pulse to fetch
fetch_done  in  1  fetch complete
decode_enable  out  1  one-cycle start pulse to decode
decode_done  in  1  decode complete
exec_enable  out  1  one-cycle start pulse to execute
exec_done  in  1  execute complete
mem_req  in  1  sampled with exec_done; instruction needs the memory stage
branch_taken  in  1  sampled with exec_done; redirect the PC
branch_target  in  PC_W  sampled with exec_done
halt_req  in  1  sampled with exec_done; stop after this instruction
mem_enable  out  1  one-cycle start pulse to memory
mem_done  in  1  memory complete
wb_enable  out  1  one-cycle start pulse to write-back
wb_done  in  1  write-back complete
pc  out  PC_W  address of the current instruction
instr_count  out  32  retired instructions, wraps modulo 2^32
busy  out  1  high in FETCH, DECODE, EXEC, MEM and WB
halted  out  1  high in HALT
error  out  1  high in ERROR (watchdog fired)

Behaviour:
- Reset (async, rst=1) sets: state=IDLE, pc=RESET_PC, instr_count=0, all enables 0, latched flags 0, watchdog 0, busy/halted/error 0. Reset asserted mid-instruction aborts it immediately; no retire and no PC update.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR. The state register and all outputs are registered.
- Stage entry: the clock edge that moves the FSM into a stage state also sets that stage's enable. The enable is high for exactly the first cycle in the stage and is cleared on the next edge. The watchdog is cleared on entry.
- Done acceptance: a stage's done is accepted only while in that stage with its enable low. Done in the enable cycle, or done from a non-active stage, is ignored. Minimum stage time is 2 cycles.
- Transitions:
  - IDLE or HALT, start=1 -> FETCH.
  - FETCH, done -> DECODE.
  - DECODE, done -> EXEC.
  - EXEC, done -> MEM if mem_req, else WB. On the same edge, mem_req, branch_taken, branch_target and halt_req are latched.
  - MEM, done -> WB.
  - WB, done -> retire.
- Retire (same edge as leaving WB):
  - instr_count += 1.
  - pc <= latched branch_target if branch taken, else pc+1, wrapping modulo 2^PC_W.
  - Next state is HALT if halt latched, else FETCH with fetch_enable pulsed.
- Minimum instruction latency: 8 cycles without MEM, 10 with MEM.
- Watchdog (TIMEOUT>0): counts cycles in a stage state after entry. If TIMEOUT cycles elapse with no accepted done, the FSM goes to ERROR.
  - ERROR: error=1, enables 0, pc and instr_count frozen.
  - ERROR exits only on rst; start is ignored.
- HALT: pc already points at the next instruction; start resumes from it.
- start while busy: ignored, no effect on the current instruction.

Test Plan:
- Reset, start pulse, every stage returns done 1 cycle after its enable, mem_req=0 -> enables pulse in order F, D, X, W; instr_count=1; pc=1; second fetch_enable 8 cycles after the first.
- Instruction with mem_req=1, branch_taken=1, branch_target=0x100 -> mem_enable pulses; after wb_done, pc=0x100 and fetch_enable fires.
- Execute asserts exec_done in the same cycle as exec_enable, and decode_done spuriously during EXEC -> both ignored; the state advances only on a later exec_done.
- halt_req=1 on the 3rd instruction -> halted=1, pc=3, instr_count=3; start -> fetch resumes at pc=3.
- TIMEOUT=16, fetch_done never returned -> error=1 sixteen cycles after fetch_enable; start ignored; rst clears to IDLE, pc=RESET_PC.
- rst asserted in MEM -> outputs return to reset values asynchronously (before the next clk edge), instr_count unchanged from 0.
